imem_load_ctrl: RTL and testbench



---
 rtl/imem_load_ctrl_if.sv | 22 ++
 rtl/imem_load_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_imem_load_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_load_ctrl_if.sv
// Write port from the memory-load sequencer into the core's instruction memory.
// The sequencer is the master: it drives the address, the word and the strobe.
interface imem_load_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_BYTES = 5
);
  logic [ADDR_WIDTH-1:0]   imem_write_adr;
  logic [8*DATA_BYTES-1:0] imem_in;
  logic                    imem_write;

  modport master (
    output imem_write_adr,
    output imem_in,
    output imem_write
  );

  modport slave (
    input imem_write_adr,
    input imem_in,
    input imem_write
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Framed instruction-memory loader: takes bytes strobed in from the pads,
// assembles address and data records, checks a per-word XOR checksum and
// issues single-cycle write commands into the imem port.
module imem_load_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_BYTES = 5
) (
  input  logic                  clk_int,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [7:0]            byte_in,
  input  logic                  strobe_in,
  imem_load_ctrl_if.master      imem,
  output logic                  busy,
  output logic                  chk_error,
  output logic                  wrap_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int WORD_W = 8 * DATA_BYTES;
  localparam int IDX_W  = $clog2(DATA_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_CHECK,
    S_WRITE
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          byte_s1_q, byte_s1_d, byte_s2_q, byte_s2_d;
  logic                strobe_s1_q, strobe_s1_d, strobe_s2_q, strobe_s2_d;
  logic                strobe_prev_q, strobe_prev_d;
  logic                load_en_prev_q, load_en_prev_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [7:0]          xor_q, xor_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                chk_error_q, chk_error_d;
  logic                wrap_error_q, wrap_error_d;
  logic [ADDR_WIDTH:0] word_count_q, word_count_d;

  logic byte_valid;
  logic load_start;

  // A byte is taken on the first cycle the synchronised strobe is seen high;
  // a load starts on the first cycle load_en is seen high.
  assign byte_valid = strobe_s2_q & ~strobe_prev_q;
  assign load_start = load_en & ~load_en_prev_q;

  // Synchroniser chains, record assembly and sequencing.
  always_comb begin
    byte_s1_d      = byte_in;
    byte_s2_d      = byte_s1_q;
    strobe_s1_d    = strobe_in;
    strobe_s2_d    = strobe_s1_q;
    strobe_prev_d  = strobe_s2_q;
    load_en_prev_d = load_en;

    state_d      = state_q;
    addr_d       = addr_q;
    word_d       = word_q;
    xor_d        = xor_q;
    idx_d        = idx_q;
    chk_error_d  = chk_error_q;
    wrap_error_d = wrap_error_q;
    word_count_d = word_count_q;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          chk_error_d  = 1'b0;
          wrap_error_d = 1'b0;
          word_count_d = '0;
          idx_d        = '0;
          xor_d        = '0;
          state_d      = S_ADDR_HI;
        end
      end
      S_ADDR_HI: begin
        if (byte_valid) begin
          // Upper byte bits beyond the address width are simply dropped.
          addr_d  = {byte_s2_q[ADDR_WIDTH-9:0], addr_q[7:0]};
          state_d = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (byte_valid) begin
          addr_d  = {addr_q[ADDR_WIDTH-1:8], byte_s2_q};
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (byte_valid) begin
          // Shift left so the first data byte ends up in the MSB.
          word_d = WORD_W'({word_q, byte_s2_q});
          xor_d  = xor_q ^ byte_s2_q;
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (byte_valid) begin
          if (byte_s2_q == xor_q) begin
            state_d = S_WRITE;
          end else begin
            // Bad word is thrown away; the address stays for the retry.
            chk_error_d = 1'b1;
            xor_d       = '0;
            idx_d       = '0;
            state_d     = S_DATA;
          end
        end
      end
      S_WRITE: begin
        // The pulse is already on the bus this cycle, so its bookkeeping
        // is done even if load_en drops at the same time.
        if (!(&word_count_q)) begin
          word_count_d = word_count_q + (ADDR_WIDTH+1)'(1);
        end
        if (&addr_q) begin
          wrap_error_d = 1'b1;
        end
        addr_d  = addr_q + ADDR_WIDTH'(1);
        xor_d   = '0;
        idx_d   = '0;
        state_d = S_DATA;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Leaving memload mode aborts whatever record is in flight.
    if (!load_en) begin
      state_d = S_IDLE;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_int) begin
    if (reset) begin
      state_q        <= S_IDLE;
      byte_s1_q      <= '0;
      byte_s2_q      <= '0;
      strobe_s1_q    <= 1'b0;
      strobe_s2_q    <= 1'b0;
      strobe_prev_q  <= 1'b0;
      load_en_prev_q <= 1'b0;
      addr_q         <= '0;
      word_q         <= '0;
      xor_q          <= '0;
      idx_q          <= '0;
      chk_error_q    <= 1'b0;
      wrap_error_q   <= 1'b0;
      word_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      byte_s1_q      <= byte_s1_d;
      byte_s2_q      <= byte_s2_d;
      strobe_s1_q    <= strobe_s1_d;
      strobe_s2_q    <= strobe_s2_d;
      strobe_prev_q  <= strobe_prev_d;
      load_en_prev_q <= load_en_prev_d;
      addr_q         <= addr_d;
      word_q         <= word_d;
      xor_q          <= xor_d;
      idx_q          <= idx_d;
      chk_error_q    <= chk_error_d;
      wrap_error_q   <= wrap_error_d;
      word_count_q   <= word_count_d;
    end
  end

  assign imem.imem_write_adr = addr_q;
  assign imem.imem_in        = word_q;
  assign imem.imem_write     = (state_q == S_WRITE);
  assign busy                = (state_q != S_IDLE);
  assign chk_error           = chk_error_q;
  assign wrap_error          = wrap_error_q;
  assign word_count          = word_count_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: directed records from the test plan followed by
// random records, checked against a record-level model of the load protocol.
module tb_imem_load_ctrl;

  localparam int AW = 10;
  localparam int DB = 5;
  localparam int WW = 8 * DB;

  logic          clk_int = 1'b0;
  logic          reset = 1'b1;
  logic          load_en = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          strobe_in = 1'b0;
  logic          busy, chk_error, wrap_error;
  logic [AW:0]   word_count;

  imem_load_ctrl_if #(.ADDR_WIDTH(AW), .DATA_BYTES(DB)) imem ();

  imem_load_ctrl #(.ADDR_WIDTH(AW), .DATA_BYTES(DB)) dut (
    .clk_int    (clk_int),
    .reset      (reset),
    .load_en    (load_en),
    .byte_in    (byte_in),
    .strobe_in  (strobe_in),
    .imem       (imem.master),
    .busy       (busy),
    .chk_error  (chk_error),
    .wrap_error (wrap_error),
    .word_count (word_count)
  );

  always #5 clk_int = ~clk_int;

  int cyc = 0;
  always @(posedge clk_int) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Record-level model: where the next good word goes and what the flags read.
  typedef struct {
    logic [AW-1:0] a;
    logic [WW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [AW-1:0] m_addr = '0;
  int            m_count = 0;
  bit            m_chk = 0;
  bit            m_wrap = 0;
  int            last_rise = 0;
  logic          prev_wr = 1'b0;
  localparam int MAX_COUNT = (1 << (AW + 1)) - 1;

  // Write monitor: every pulse must match the next expected write, be one
  // cycle long and come 3 cycles after the check byte's strobe rise.
  always @(negedge clk_int) begin
    if (imem.imem_write === 1'b1) begin
      check_eq("pulse_single", prev_wr, 0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("wr_adr", imem.imem_write_adr, mon_e.a);
        check_eq("wr_data", imem.imem_in, mon_e.d);
        check_eq("wr_latency", cyc - last_rise, 3);
        $display("write adr=0x%0h data=0x%0h at cycle %0d", imem.imem_write_adr, imem.imem_in, cyc);
      end
    end
    prev_wr = imem.imem_write;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_int);
    #1;
  endtask

  // Byte respects the source rules: stable 3 cycles before the rise, strobe
  // high for hi cycles (0 picks 3..5), low for 3..5 cycles afterwards.
  task automatic send_byte(input logic [7:0] b, input int hi);
    byte_in = b;
    tick(3);
    strobe_in = 1'b1;
    last_rise = cyc;
    tick(hi == 0 ? $urandom_range(3, 5) : hi);
    strobe_in = 1'b0;
    tick($urandom_range(3, 5));
  endtask

  task automatic start_load();
    load_en = 1'b0;
    tick(2);
    load_en = 1'b1;
    tick(2);
    m_chk = 0;
    m_wrap = 0;
    m_count = 0;
    check_eq("busy_start", busy, 1);
  endtask

  task automatic send_addr(input logic [AW-1:0] a, input int hi);
    logic [31:0] r;
    logic [7:0]  hb;
    r  = $urandom;
    hb = {r[5:0], a[9:8]};
    send_byte(hb, hi);
    send_byte(a[7:0], hi);
    m_addr = a;
  endtask

  // Sends one word; abort_after >= 0 drops load_en after that many data bytes.
  task automatic send_word(input logic [WW-1:0] d, input bit bad, input int hi, input int abort_after);
    logic [7:0] x;
    logic [7:0] b;
    logic [7:0] cb;
    x = 8'h00;
    for (int i = 0; i < DB; i++) begin
      if (i == abort_after) begin
        load_en = 1'b0;
        tick(1);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_count", word_count, m_count);
        $display("abort after %0d data bytes", i);
        return;
      end
      b = d[WW-1-8*i -: 8];
      x = x ^ b;
      send_byte(b, hi);
    end
    cb = bad ? (x ^ 8'($urandom_range(1, 255))) : x;
    if (!bad) exp_q.push_back('{a: m_addr, d: d});
    send_byte(cb, hi);
    if (bad) begin
      m_chk = 1;
    end else begin
      if (m_count < MAX_COUNT) m_count++;
      if (m_addr == {AW{1'b1}}) m_wrap = 1;
      m_addr = m_addr + 1'b1;
    end
    $display("word data=0x%0h check=0x%0h bad=%0d", d, cb, bad);
    check_eq("adr_after", imem.imem_write_adr, m_addr);
    check_eq("chk_error", chk_error, m_chk);
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_count"}, word_count, m_count);
    check_eq({tag, "_chk"}, chk_error, m_chk);
    check_eq({tag, "_wrap"}, wrap_error, m_wrap);
  endtask

  function automatic logic [WW-1:0] rand_word();
    logic [31:0] lo;
    logic [31:0] hi;
    lo = $urandom;
    hi = $urandom;
    return {hi[WW-33:0], lo};
  endfunction

  initial begin
    int nw;
    int ab_word;
    int ab_idx;
    logic [31:0] ra;

    tick(3);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_write", imem.imem_write, 0);
    check_eq("rst_adr", imem.imem_write_adr, 0);
    check_eq("rst_data", imem.imem_in, 0);
    check_eq("rst_flags", {chk_error, wrap_error}, 0);
    check_eq("rst_count", word_count, 0);
    reset = 1'b0;
    tick(2);

    // Basic word with strobe high exactly 3 cycles.
    start_load();
    send_addr(10'h210, 3);
    send_word(40'h11_2233_4455, 0, 3, -1);
    check_status("basic");

    // Bad check byte, then the same word again at the same address.
    start_load();
    send_addr(10'h210, 0);
    send_word(40'h11_2233_4455, 1, 0, -1);
    send_word(40'h11_2233_4455, 0, 0, -1);
    check_status("badchk");

    // Wrap past the top address.
    start_load();
    send_addr(10'h3FF, 0);
    send_word(rand_word(), 0, 0, -1);
    send_word(rand_word(), 0, 0, -1);
    check_status("wrap");

    // Abort mid-word, then a clean record.
    start_load();
    send_addr(10'h155, 0);
    send_word(rand_word(), 0, 0, 3);
    check_status("abort");
    start_load();
    send_addr(10'h155, 0);
    send_word(rand_word(), 0, 0, -1);
    check_status("after_abort");

    // Reset in the middle of a word with flags and count non-zero.
    start_load();
    send_addr(10'h0A5, 0);
    send_word(rand_word(), 0, 0, -1);
    send_word(rand_word(), 1, 0, -1);
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    reset = 1'b1;
    load_en = 1'b0;
    tick(1);
    m_addr = '0; m_count = 0; m_chk = 0; m_wrap = 0;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_adr", imem.imem_write_adr, 0);
    check_eq("mid_rst_data", imem.imem_in, 0);
    check_status("mid_rst");
    reset = 1'b0;
    tick(1);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    check_eq("idle_busy", busy, 0);
    check_status("idle_strobes");

    // Random records.
    for (int r = 0; r < 30; r++) begin
      ra = $urandom;
      nw = $urandom_range(1, 3);
      ab_word = ($urandom_range(0, 99) < 15) ? $urandom_range(0, nw - 1) : -1;
      ab_idx = $urandom_range(0, DB - 1);
      start_load();
      send_addr(ra[AW-1:0], 0);
      $display("record %0d adr=0x%0h words=%0d", r, ra[AW-1:0], nw);
      for (int w = 0; w < nw; w++) begin
        if (w == ab_word) begin
          send_word(rand_word(), 0, 0, ab_idx);
          break;
        end
        send_word(rand_word(), ($urandom_range(0, 3) == 0), 0, -1);
      end
      check_status("rand");
    end

    load_en = 1'b0;
    tick(5);
    check_eq("pending_writes", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
